dht11_disp: RTL and testbench
=============================

DHT11_DISP -- requirements
Module: dht11_disp

Interface
REQ-001 Parameter SCAN_CNT, default 50_000-1, per-digit dwell in clk cycles (1 ms at 50 MHz).
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-004 data  input  32  sensor word: [31:24] humidity int, [23:16] humidity dec, [15:8] temp int, [7:0] temp dec; may change on any clk edge.
REQ-005 hum_bcd  output  12  humidity integer as 3 BCD digits (hundreds, tens, units).
REQ-006 temp_bcd  output  12  temperature integer as 3 BCD digits.
REQ-007 upd  output  1  one-cycle pulse when hum_bcd/temp_bcd change.
REQ-008 seg  output  8  7-seg segments, active-low, seg[7]=dp, seg[6:0]=g..a.
REQ-009 sel  output  6  digit select, active-low one-hot; sel[5] leftmost.

Function
REQ-010 Converter FSM states IDLE, CONV, DONE; all transitions on clk rising edge.
REQ-011 IDLE: if {data[31:24],data[15:8]} differs from last-captured pair, SHALL capture the pair into source regs and go CONV; else stay.
REQ-012 CONV: 8 cycles of double-dabble (add 3 to any BCD nibble >=5, then shift left 1) on both bytes in parallel; bit counter 0..7; at 7 go DONE.
REQ-013 DONE: load hum_bcd/temp_bcd, assert upd for exactly this cycle, go IDLE.
REQ-014 Latency: upd high exactly 10 clk cycles after the edge where IDLE captures the new pair.
REQ-015 Data changes during CONV/DONE SHALL be ignored; re-evaluated on return to IDLE against the captured pair (no lost final value).
REQ-016 Identical data re-presented SHALL NOT trigger a conversion or upd.
REQ-017 Decimal bytes [23:16],[7:0] SHALL be ignored.
REQ-018 Scan counter counts 0..SCAN_CNT then wraps; at wrap digit index advances 0..5, wraps 5->0.
REQ-019 Index k drives sel[5-k] low, others high; digits left-to-right: hum hundreds, tens, units, temp hundreds, tens, units.
REQ-020 seg encoding 0-9: C0,F9,A4,B0,99,92,82,F8,80,90 (hex); dp off except on hum units digit (separator).
REQ-021 seg and sel SHALL be registered and change in the same cycle (no ghosting between digits).

Reset
REQ-022 Asynchronous assertion; all regs cleared immediately: FSM=IDLE, captured pair=16'h0000, hum_bcd=temp_bcd=0, upd=0, scan counter=0, index=0.
REQ-023 During reset seg=8'hFF, sel=6'b111111; after release first digit driven on the first clk edge.
REQ-024 Reset mid-CONV SHALL abort conversion with no upd; data=0 after release causes no conversion (matches cleared pair).

Configuration
REQ-025 Macro DHT11_DISP_BLANK_EN: when defined, leading-zero blanking: hundreds digit blank (seg=8'hFF, dp per REQ-020) if 0; tens blank if hundreds and tens both 0; units never blank.
REQ-026 Without DHT11_DISP_BLANK_EN all six digits always show numerals; hum_bcd/temp_bcd identical in both builds.

Verification
REQ-027 Release reset, data=32'h3C00_1900 -> 10 cycles after capture: hum_bcd=12'h060, temp_bcd=12'h025, single upd pulse.
REQ-028 data=32'hFF00_0000 -> hum_bcd=12'h255, temp_bcd=12'h000; with BLANK_EN temp digits show blank,blank,C0.
REQ-029 Change data 3 times within CONV (final 32'h5000_1E00) -> exactly two upd pulses total, final hum_bcd=12'h080, temp_bcd=12'h030.
REQ-030 SCAN_CNT=3, digits 060/025 -> sel cycles 011111..111110 every 4 clks, seg sequence C0,82,40,C0,A4,92 (no blank build).
REQ-031 Assert sys_rst_n low during CONV -> seg=FF, sel=3F immediately, no upd, bcd outputs 0.
REQ-032 Re-apply same data word after conversion -> no upd, FSM stays IDLE.

Source files
------------

// File: rtl/dht11_disp.sv
// dht11_disp: converts the integer humidity and temperature bytes of a DHT11
// sensor word to BCD and multiplexes them onto a six-digit, active-low
// 7-segment display.
//
// Ports:
//   clk        system clock (50 MHz)
//   sys_rst_n  asynchronous active-low reset
//   data       sensor word {hum int, hum dec, temp int, temp dec}
//   hum_bcd    humidity integer, 3 BCD digits (hundreds, tens, units)
//   temp_bcd   temperature integer, 3 BCD digits
//   upd        one-cycle pulse when hum_bcd/temp_bcd are reloaded
//   seg        segments, active-low, seg[7]=dp, seg[6:0]=g..a
//   sel        digit select, active-low one-hot, sel[5] leftmost
//
// Build option: define DHT11_DISP_BLANK_EN to blank leading zeros on the
// hundreds and tens digits of each value.

module dht11_disp #(
    parameter int unsigned SCAN_CNT = 50_000 - 1
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic [31:0] data,
    output logic [11:0] hum_bcd,
    output logic [11:0] temp_bcd,
    output logic        upd,
    output logic [7:0]  seg,
    output logic [5:0]  sel
);

    localparam int unsigned SCAN_W = (SCAN_CNT < 1) ? 1 : $clog2(SCAN_CNT + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              r_state, w_next;
    logic [15:0]         r_pair;
    logic [2:0]          r_bit;
    logic [11:0]         r_hacc, r_tacc;
    logic [11:0]         r_hum_bcd, r_temp_bcd;
    logic                r_pend, r_upd;
    logic [SCAN_W-1:0]   r_scan;
    logic [2:0]          r_idx;
    logic [7:0]          r_seg;
    logic [5:0]          r_sel;

    logic [15:0]         w_pair;
    logic [2:0]          w_bidx;
    logic [3:0]          w_digit;
    logic                w_dp, w_blank;
    logic [6:0]          w_pat;
    logic                w_unused;

    assign w_pair   = {data[31:24], data[15:8]};
    assign w_bidx   = 3'd7 - r_bit;
    assign w_unused = ^{data[23:16], data[7:0]};

    // One double-dabble step: correct nibbles >= 5, then shift in next bit.
    function automatic logic [11:0] dd_step(input logic [11:0] acc, input logic bin);
        logic [11:0] adj;
        adj = acc;
        for (int unsigned i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[10:0], bin};
    endfunction

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_pair != r_pair) w_next = CONV;
            CONV:    if (r_bit == 3'd7) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Results pass through r_pend so bcd outputs and upd change together,
    // ten cycles after the capture edge.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= IDLE;
            r_pair     <= '0;
            r_bit      <= '0;
            r_hacc     <= '0;
            r_tacc     <= '0;
            r_hum_bcd  <= '0;
            r_temp_bcd <= '0;
            r_pend     <= 1'b0;
            r_upd      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pend  <= 1'b0;
            r_upd   <= r_pend;
            if (r_pend) begin
                r_hum_bcd  <= r_hacc;
                r_temp_bcd <= r_tacc;
            end
            case (r_state)
                IDLE: begin
                    if (w_pair != r_pair) begin
                        r_pair <= w_pair;
                        r_bit  <= '0;
                        r_hacc <= '0;
                        r_tacc <= '0;
                    end
                end
                CONV: begin
                    r_hacc <= dd_step(r_hacc, r_pair[8 + w_bidx]);
                    r_tacc <= dd_step(r_tacc, r_pair[w_bidx]);
                    r_bit  <= r_bit + 3'd1;
                end
                DONE:    r_pend <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_digit = '0;
        case (r_idx)
            3'd0:    w_digit = r_hum_bcd[11:8];
            3'd1:    w_digit = r_hum_bcd[7:4];
            3'd2:    w_digit = r_hum_bcd[3:0];
            3'd3:    w_digit = r_temp_bcd[11:8];
            3'd4:    w_digit = r_temp_bcd[7:4];
            3'd5:    w_digit = r_temp_bcd[3:0];
            default: w_digit = '0;
        endcase
    end

    assign w_dp = (r_idx == 3'd2);

`ifdef DHT11_DISP_BLANK_EN
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            3'd0:    w_blank = (r_hum_bcd[11:8] == 4'd0);
            3'd1:    w_blank = (r_hum_bcd[11:4] == 8'd0);
            3'd3:    w_blank = (r_temp_bcd[11:8] == 4'd0);
            3'd4:    w_blank = (r_temp_bcd[11:4] == 8'd0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_pat = 7'h7F;
        if (!w_blank) begin
            case (w_digit)
                4'd0:    w_pat = 7'h40;
                4'd1:    w_pat = 7'h79;
                4'd2:    w_pat = 7'h24;
                4'd3:    w_pat = 7'h30;
                4'd4:    w_pat = 7'h19;
                4'd5:    w_pat = 7'h12;
                4'd6:    w_pat = 7'h02;
                4'd7:    w_pat = 7'h78;
                4'd8:    w_pat = 7'h00;
                4'd9:    w_pat = 7'h10;
                default: w_pat = 7'h7F;
            endcase
        end
    end

    // seg and sel share one register stage so both switch on the same edge.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_seg  <= '1;
            r_sel  <= '1;
        end else begin
            if (r_scan == SCAN_W'(SCAN_CNT)) begin
                r_scan <= '0;
                r_idx  <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_scan <= r_scan + 1'b1;
            end
            r_seg <= {~w_dp, w_pat};
            r_sel <= ~(6'b100000 >> r_idx);
        end
    end

    assign hum_bcd  = r_hum_bcd;
    assign temp_bcd = r_temp_bcd;
    assign upd      = r_upd;
    assign seg      = r_seg;
    assign sel      = r_sel;

endmodule

// File: tb/tb_dht11_disp.sv
// tb_dht11_disp: directed self-checking bench for dht11_disp (SCAN_CNT=3,
// default build without leading-zero blanking).

module tb_dht11_disp;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic [31:0] data;
    logic [11:0] hum_bcd, temp_bcd;
    logic        upd;
    logic [7:0]  seg;
    logic [5:0]  sel;

    int total = 0;
    int bad   = 0;
    int edges;
    int c;

    always #5 clk = ~clk;

    dht11_disp #(.SCAN_CNT(3)) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .data      (data),
        .hum_bcd   (hum_bcd),
        .temp_bcd  (temp_bcd),
        .upd       (upd),
        .seg       (seg),
        .sel       (sel)
    );

    // Clock edges seen since reset release; drives the expected digit index.
    always @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) edges <= 0;
        else            edges <= edges + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_upd(output int cyc);
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (upd === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic count_upd(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (upd === 1'b1) cnt++;
        end
    endtask

    // segs holds the six expected seg bytes, leftmost digit in the top byte.
    task automatic scan_chk(input string tag, input logic [47:0] segs, input int n);
        for (int k = 0; k < n; k++) begin
            int idx;
            step();
            idx = ((edges - 1) / 4) % 6;
            chk(tag, {18'h0, sel, seg},
                {18'h0, ~(6'b100000 >> idx), segs[8*(5-idx) +: 8]});
        end
    endtask

    initial begin
        sys_rst_n = 1'b1;
        data      = 32'h0;
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_seg",  {24'h0, seg}, 32'hFF);
        chk("rst_sel",  {26'h0, sel}, 32'h3F);
        chk("rst_upd",  {31'h0, upd}, 32'h0);
        chk("rst_hum",  {20'h0, hum_bcd}, 32'h000);
        chk("rst_temp", {20'h0, temp_bcd}, 32'h000);
        repeat (2) step();
        chk("rst_hold_segsel", {18'h0, sel, seg}, {18'h0, 6'h3F, 8'hFF});

        @(negedge clk) sys_rst_n = 1'b1;
        step();
        chk("first_digit", {18'h0, sel, seg}, {18'h0, 6'b011111, 8'hC0});
        count_upd(15, c);
        chk("zero_data_no_conv", c, 0);

        // 0x3C=60, 0x19=25
        @(negedge clk) data = 32'h3C00_1900;
        wait_upd(c);
        chk("latency_3c19", c, 11);
        chk("hum_060",  {20'h0, hum_bcd}, 32'h060);
        chk("temp_025", {20'h0, temp_bcd}, 32'h025);
        count_upd(12, c);
        chk("single_pulse_3c19", c, 0);
        scan_chk("scan_060_025", 48'hC0_82_40_C0_A4_92, 24);

        // 0xFF=255, temp 0
        @(negedge clk) data = 32'hFF00_0000;
        wait_upd(c);
        chk("latency_ff00", c, 11);
        chk("hum_255",  {20'h0, hum_bcd}, 32'h255);
        chk("temp_000", {20'h0, temp_bcd}, 32'h000);
        step();
        scan_chk("scan_255_000", 48'hA4_92_12_C0_C0_C0, 12);

        // Same integer bytes, decimal bytes changed: no conversion
        @(negedge clk) data = 32'hFF12_0034;
        count_upd(20, c);
        chk("same_data_no_upd", c, 0);
        chk("hum_kept_255", {20'h0, hum_bcd}, 32'h255);

        // Three changes while converting; final value picked up afterwards
        @(negedge clk) data = 32'h1400_0A00;
        step();
        @(negedge clk) data = 32'h2200_0B00;
        step();
        @(negedge clk) data = 32'h3300_0C00;
        step();
        @(negedge clk) data = 32'h5000_1E00;
        wait_upd(c);
        chk("first_pulse_pos", c, 8);
        chk("hum_020",  {20'h0, hum_bcd}, 32'h020);
        chk("temp_010", {20'h0, temp_bcd}, 32'h010);
        count_upd(20, c);
        chk("second_pulse_only", c, 1);
        chk("hum_080",  {20'h0, hum_bcd}, 32'h080);
        chk("temp_030", {20'h0, temp_bcd}, 32'h030);

        // Reset during conversion
        @(negedge clk) data = 32'h0100_0200;
        step();
        step();
        step();
        #2 sys_rst_n = 1'b0;
        #1;
        chk("midconv_rst_segsel", {18'h0, sel, seg}, {18'h0, 6'h3F, 8'hFF});
        chk("midconv_rst_upd",  {31'h0, upd}, 32'h0);
        chk("midconv_rst_hum",  {20'h0, hum_bcd}, 32'h000);
        chk("midconv_rst_temp", {20'h0, temp_bcd}, 32'h000);
        data = 32'h0;
        repeat (2) step();
        @(negedge clk) sys_rst_n = 1'b1;
        step();
        chk("post_rst_digit", {18'h0, sel, seg}, {18'h0, 6'b011111, 8'hC0});
        count_upd(20, c);
        chk("post_rst_no_upd", c, 0);
        chk("post_rst_hum", {20'h0, hum_bcd}, 32'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
